// File: rtl/quadrant_scan_fsm.sv
// rtl/quadrant_scan_fsm.sv - one-hot channel sweep sequencer with dwell, mask, hold and continuous mode
module quadrant_scan_fsm #(
  parameter int N_CH    = 4,
  parameter int DWELL_W = 8,
  parameter int IDX_W   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               T,
  input  logic               mode,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N_CH-1:0]    mask,
  output logic [N_CH-1:0]    quadrant,
  output logic [IDX_W-1:0]   index,
  output logic               busy,
  output logic               sweep_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   ch;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic               done_q;

  // Lowest masked channel above c; 0 (home) when none remain. mask[0] can never win since j > c >= 0.
  function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] c, input logic [N_CH-1:0] m);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if ((j > int'(c)) && m[j]) n = IDX_W'(j);
    end
    return n;
  endfunction

  logic [IDX_W-1:0] nxt;
  always_comb begin
    nxt = next_ch((state == S_IDLE) ? '0 : ch, mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ch      <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          ch  <= '0;
          if (T && !hold) begin
            dwell_q <= dwell;
            ch      <= nxt;
            if (nxt == '0) done_q <= 1'b1;
            else           state  <= S_SCAN;
          end
        end
        default: begin
          if (!hold) begin
            if (cnt == dwell_q) begin
              ch      <= nxt;
              cnt     <= '0;
              dwell_q <= dwell;
              if (nxt == '0) begin
                done_q <= 1'b1;
                if (!mode) state <= S_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign quadrant   = N_CH'(1) << ch;
  assign index      = ch;
  assign busy       = (state == S_SCAN);
  assign sweep_done = done_q;

endmodule

// File: tb/tb_quadrant_scan_fsm.sv
// tb/tb_quadrant_scan_fsm.sv - directed-vector bench for quadrant_scan_fsm at N_CH=4
module tb_quadrant_scan_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       T;
  logic       mode;
  logic       hold;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic [3:0] quadrant;
  logic [1:0] index;
  logic       busy;
  logic       sweep_done;

  int vectors = 0;
  int errors  = 0;

  quadrant_scan_fsm dut (
    .clk(clk), .rst(rst), .T(T), .mode(mode), .hold(hold), .dwell(dwell), .mask(mask),
    .quadrant(quadrant), .index(index), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; T = 1'b0; mode = 1'b0; hold = 1'b0; dwell = 8'd0; mask = 4'b1111;
    tick();
    vectors++;
    if (quadrant !== 4'b0001 || index !== 2'd0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got q=%b i=%0d b=%b sd=%b expected q=0001 i=0 b=0 sd=0", quadrant, index, busy, sweep_done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [4];
    exp_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dwell = 8'd0; mask = 4'b1111; mode = 1'b0;
    T = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) T = 1'b0;          // T held high through ch1 must be ignored
      vectors++;
      if (i < 4 && quadrant !== exp_q[i]) begin
        errors++;
        $display("FAIL one_shot_q[%0d]: got %b expected %b", i, quadrant, exp_q[i]);
      end
      if (sweep_done !== (i == 3) || busy !== (i < 3)) begin
        errors++;
        $display("FAIL one_shot_flags[%0d]: got sd=%b busy=%b expected sd=%b busy=%b", i, sweep_done, busy, i == 3, i < 3);
      end
    end
  endtask

  task automatic test_dwell_mask();
    logic [1:0] exp_i [9];
    exp_i = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    dwell = 8'd2; mask = 4'b1011; mode = 1'b0;
    T = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      T = 1'b0;
      vectors++;
      if (index !== exp_i[i] || sweep_done !== (i == 6)) begin
        errors++;
        $display("FAIL dwell_mask[%0d]: got i=%0d sd=%b expected i=%0d sd=%b", i, index, sweep_done, exp_i[i], i == 6);
      end
    end
  endtask

  task automatic test_continuous();
    logic [1:0] pat [8];
    pat = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    dwell = 8'd1; mask = 4'b1111; mode = 1'b1;
    T = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      T = 1'b0;
      if (i == 15) mode = 1'b0;       // takes effect at the third return home
      vectors++;
      if (index !== pat[i % 8] || sweep_done !== ((i % 8) == 6) || busy !== (i < 22)) begin
        errors++;
        $display("FAIL continuous[%0d]: got i=%0d sd=%b b=%b expected i=%0d sd=%b b=%b",
                 i, index, sweep_done, busy, pat[i % 8], (i % 8) == 6, i < 22);
      end
    end
  endtask

  task automatic test_hold();
    logic [1:0] exp_i [13];
    exp_i = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    dwell = 8'd1; mask = 4'b1111; mode = 1'b0;
    T = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      T = 1'b0;
      if (i == 2) hold = 1'b1;
      if (i == 7) hold = 1'b0;
      vectors++;
      if (index !== exp_i[i] || sweep_done !== (i == 11)) begin
        errors++;
        $display("FAIL hold[%0d]: got i=%0d sd=%b expected i=%0d sd=%b", i, index, sweep_done, exp_i[i], i == 11);
      end
    end
  endtask

  task automatic test_degenerate();
    mask = 4'b0001; dwell = 8'd0; mode = 1'b0;
    hold = 1'b1; T = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold_blocks_T: got b=%b sd=%b expected b=0 sd=0", busy, sweep_done);
    end
    hold = 1'b0;
    tick();
    T = 1'b0;
    vectors++;
    if (quadrant !== 4'b0001 || busy !== 1'b0 || sweep_done !== 1'b1) begin
      errors++;
      $display("FAIL degenerate: got q=%b b=%b sd=%b expected q=0001 b=0 sd=1", quadrant, busy, sweep_done);
    end
    tick();
    vectors++;
    if (sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL degenerate_pulse_width: got sd=%b expected 0", sweep_done);
    end
  endtask

  task automatic test_async_reset();
    mask = 4'b1111; dwell = 8'd3; mode = 1'b0;
    T = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      T = 1'b0;
    end
    vectors++;
    if (index !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_ch: got %0d expected 2", index);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (quadrant !== 4'b0001 || index !== 2'd0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got q=%b i=%0d b=%b sd=%b expected q=0001 i=0 b=0 sd=0", quadrant, index, busy, sweep_done);
    end
    #1 rst = 1'b0;
    dwell = 8'd0;
    T = 1'b1;
    tick();
    T = 1'b0;
    vectors++;
    if (quadrant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_reset: got q=%b b=%b expected q=0010 b=1", quadrant, busy);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_dwell_mask();
    test_continuous();
    test_hold();
    test_degenerate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
